// File: rtl/bist_pattern_seq.sv
// Memory-BIST pattern sequencer: writes then read-compares six background patterns
// over every address, and records the first read mismatch.
module bist_pattern_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic              re,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [2:0]        pat_idx,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_pat
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] LAST_PAT = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [2:0]        pidx;

    logic              re_d;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        pat_d;

    logic              run_start;
    logic              cnt_last;

    function automatic logic [DATA_W-1:0] pattern(input logic [2:0] idx);
        logic [DATA_W-1:0] cb;
        logic [DATA_W-1:0] hl;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            cb[j] = j[0];
            hl[j] = (j >= DATA_W / 2);
        end
        case (idx)
            3'd0:    pattern = cb;
            3'd1:    pattern = ~cb;
            3'd2:    pattern = hl;
            3'd3:    pattern = ~hl;
            3'd4:    pattern = '0;
            3'd5:    pattern = '1;
            default: pattern = '0;
        endcase
    endfunction

    assign run_start = (state == S_IDLE) && start && !abort;
    assign cnt_last  = &cnt;

    // Internal counters lead the registered strobe/address outputs by one cycle,
    // so the first write strobe appears one cycle after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pidx    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            pat_idx <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            we    <= 1'b0;
            re    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    we <= 1'b0;
                    re <= 1'b0;
                    if (run_start) begin
                        state   <= S_WRITE;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        pidx    <= '0;
                        addr    <= '0;
                        pat_idx <= '0;
                    end
                end
                S_WRITE: begin
                    re <= 1'b0;
                    if (hold) begin
                        we <= 1'b0;
                    end else begin
                        we      <= 1'b1;
                        addr    <= cnt;
                        wdata   <= pattern(pidx);
                        pat_idx <= pidx;
                        if (cnt_last) begin
                            state <= S_READ;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    we <= 1'b0;
                    if (hold) begin
                        re <= 1'b0;
                    end else begin
                        re      <= 1'b1;
                        addr    <= cnt;
                        pat_idx <= pidx;
                        if (cnt_last) begin
                            cnt <= '0;
                            if (pidx == LAST_PAT) begin
                                state <= S_DRAIN;
                            end else begin
                                pidx  <= pidx + 3'd1;
                                state <= S_WRITE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    we    <= 1'b0;
                    re    <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    we    <= 1'b0;
                    re    <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    we    <= 1'b0;
                    re    <= 1'b0;
                end
            endcase
        end
    end

    // Compare pipeline tracks the registered read strobe and keeps running under hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_d   <= 1'b0;
            addr_d <= '0;
            pat_d  <= '0;
        end else begin
            re_d   <= re;
            addr_d <= addr;
            pat_d  <= pat_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_pat  <= '0;
        end else if (run_start) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_pat  <= '0;
        end else if (re_d && (rdata != pattern(pat_d))) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr <= addr_d;
                fail_pat  <= pat_d;
            end
        end
    end

endmodule
